pipeline_fetch: RTL and testbench
=================================

Name: pipeline_fetch

Overview:
- Instruction fetch stage. Drives the PC and the instruction-memory read port, and feeds the IF/ID pipeline register through `if_en`, `inst_out` and `pc2_out`.
- Holds a one-entry fetch buffer, so downstream stalls never lose a returned instruction.
- Handles branch redirects, including redirects that arrive while a memory read is outstanding.
- Stops fetching after a halt opcode.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_OP, 4'hF, opcode value in inst[15:12] that stops fetching.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request; held with stable `imem_addr` until `imem_ack`.
- imem_addr  out  8  byte address of the instruction; equals the pc register.
- imem_ack  in  1  read data valid this cycle; may arrive in the same cycle as `imem_req`.
- imem_rdata  in  16  instruction word, valid when `imem_ack`=1.
- stall  in  1  downstream cannot accept an instruction this cycle.
- br_taken  in  1  redirect request, single-cycle pulse.
- br_target  in  8  redirect target, sampled when `br_taken`=1.
- if_en  out  1  load enable for the IF/ID register; IF/ID loads on this clock edge.
- inst_out  out  16  buffered instruction.
- pc2_out  out  8  address of the buffered instruction + 2.
- halted  out  1  fetch stopped on HALT_OP.

Behaviour:
- Internal registers: pc[7:0], tgt[7:0], buf_valid, buf_inst[15:0], buf_pc2[7:0], and a state register.
- States: FETCH, DRAIN, HALTED.
- Reset (`rst`=1 at the edge):
  - pc=RESET_PC, state=FETCH, buf_valid=0, buf_inst=0, buf_pc2=0, tgt=0.
  - Outputs after reset: imem_req=0 during the reset cycle, if_en=0, inst_out=0, pc2_out=0, halted=0.
  - Reset mid-request abandons the read; any later ack for it is ignored.
- Combinational outputs:
  - if_en = buf_valid & !stall & !br_taken.
  - imem_req = (state==FETCH & (!buf_valid | if_en) & !rst) | (state==DRAIN & !rst).
  - imem_addr = pc.
  - inst_out = buf_inst, pc2_out = buf_pc2.
  - halted = (state==HALTED).
- Only one read is ever outstanding. While a read waits in FETCH the buffer is empty, so the request stays asserted until ack.
- FETCH, accepted read (`imem_req` & `imem_ack` & !br_taken):
  - buf_inst <= imem_rdata; buf_pc2 <= pc+2 (mod 256, 8'hFE+2 = 8'h00); buf_valid <= 1; pc <= pc+2.
  - If imem_rdata[15:12]==HALT_OP, state <= HALTED. The halt instruction is still buffered and delivered.
- FETCH, buffer consumed with no new read (`if_en` & !ack): buf_valid <= 0.
- FETCH, consume and fill in the same cycle: buffer is replaced with the new instruction. With zero-wait memory and no stall, throughput is 1 instruction per clock.
- Latency: ack at edge N → if_en=1 in the cycle after edge N (IF/ID loads at edge N+1), unless stalled.
- stall=1: if_en=0, buffer contents held unchanged, no new request (buffer full).
- br_taken=1 (any state):
  - buf_valid <= 0 and if_en=0 in that cycle; the buffered instruction is discarded.
  - If a read is outstanding without ack this cycle (state FETCH, imem_req=1, !imem_ack): tgt <= br_target, state <= DRAIN. pc is unchanged so the old address stays stable.
  - Otherwise (no outstanding read, ack this cycle, or HALTED): pc <= br_target, state <= FETCH, and any ack data is dropped.
- DRAIN:
  - imem_req=1 at the old pc; if_en=0 because buf_valid=0.
  - On ack: data dropped, pc <= tgt, state <= FETCH.
  - A second br_taken in DRAIN updates tgt only.
- HALTED:
  - imem_req=0; the buffered halt instruction still drains through if_en.
  - Leaves HALTED only on rst or br_taken.
- Simultaneous rst and br_taken: rst wins.

Test Plan:
- Reset with RESET_PC=8'h10 → imem_addr=8'h10; imem_req=1 in the first cycle after reset; if_en=0, inst_out=0, pc2_out=0, halted=0.
- Zero-wait memory returning 16'h1234, 16'h2345, 16'h3456 at 8'h00/02/04, no stall → if_en high 3 consecutive cycles; (inst_out, pc2_out) = (1234,02), (2345,04), (3456,06).
- stall held 3 cycles with 16'h1234 buffered → if_en=0, inst_out=16'h1234 held, imem_req=0; after release: if_en=1 for one cycle, then the next fetch from 8'h02.
- 3-cycle ack latency; br_taken with target 8'h40 one cycle after the request → DRAIN: imem_addr held at the old pc until ack, returned data dropped, next request at 8'h40, first delivered pc2_out=8'h42.
- Fetch 16'hF000 at 8'h08 → delivered with pc2_out=8'h0A; halted=1, imem_req=0 thereafter; br_taken to 8'h20 → fetch resumes at 8'h20, halted=0.
- PC wrap: fetch at 8'hFE → pc2_out=8'h00; next imem_addr=8'h00.

Source files
------------

// File: rtl/pipeline_fetch.sv
// pipeline_fetch: instruction fetch stage with a one-entry fetch buffer, branch redirect and halt.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   imem_req/imem_addr    instruction read request, address held stable until imem_ack
//   imem_ack/imem_rdata   read data return (may arrive in the request cycle)
//   stall                 downstream cannot accept an instruction
//   br_taken/br_target    single-cycle redirect request and target
//   if_en                 IF/ID load enable; inst_out/pc2_out carry the buffered instruction and its pc+2
//   halted                fetching stopped after HALT_OP
module pipeline_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] HALT_OP  = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [7:0]  br_target,
    output logic        if_en,
    output logic [15:0] inst_out,
    output logic [7:0]  pc2_out,
    output logic        halted
);
    typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;
    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d, tgt_q, tgt_d, buf_pc2_q, buf_pc2_d;
    logic        buf_valid_q, buf_valid_d;
    logic [15:0] buf_inst_q, buf_inst_d;
    logic        pending;
    assign if_en     = buf_valid_q & ~stall & ~br_taken;
    assign imem_req  = ~rst & ((state_q == FETCH & (~buf_valid_q | if_en)) | state_q == DRAIN);
    assign imem_addr = pc_q;
    assign inst_out  = buf_inst_q;
    assign pc2_out   = buf_pc2_q;
    assign halted    = state_q == HALTED;
    // A read still waiting for its ack must finish at the same address before redirecting.
    assign pending   = imem_req & ~imem_ack;
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        buf_pc2_d   = buf_pc2_q;
        if (br_taken) begin
            buf_valid_d = 1'b0;
            if (pending) begin
                tgt_d   = br_target;
                state_d = DRAIN;
            end else begin
                pc_d    = br_target;
                state_d = FETCH;
            end
        end else if (state_q == FETCH) begin
            if (imem_req & imem_ack) begin
                buf_inst_d  = imem_rdata;
                buf_pc2_d   = pc_q + 8'd2;
                buf_valid_d = 1'b1;
                pc_d        = pc_q + 8'd2;
                state_d     = (imem_rdata[15:12] == HALT_OP) ? HALTED : FETCH;
            end else if (if_en) begin
                buf_valid_d = 1'b0;
            end
        end else if (state_q == DRAIN) begin
            if (imem_ack) begin
                pc_d    = tgt_q;
                state_d = FETCH;
            end
        end else if (if_en) begin
            buf_valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            tgt_q       <= 8'h00;
            buf_valid_q <= 1'b0;
            buf_inst_q  <= 16'h0000;
            buf_pc2_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
            buf_pc2_q   <= buf_pc2_d;
        end
    end
endmodule

// File: tb/tb_pipeline_fetch.sv
// tb_pipeline_fetch: randomized scoreboard bench for pipeline_fetch against a program-flow reference model.
module tb_pipeline_fetch;
    localparam logic [7:0] RPC = 8'h10;
    typedef struct packed {
        logic [15:0] inst;
        logic [7:0]  pc2;
    } exp_t;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, br_taken = 1'b0, imem_ack = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_req, if_en, halted;
    logic [7:0]  imem_addr, pc2_out;
    logic [15:0] inst_out;
    logic [15:0] mem [256];
    exp_t        q[$];
    int          vecs = 0, errs = 0;
    int          cnt = 0, lat = 0, max_lat = 0;
    logic        busy = 1'b0, halt_seen = 1'b0;
    logic [7:0]  addr_l = 8'h00;

    pipeline_fetch #(.RESET_PC(RPC), .HALT_OP(4'hF)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .if_en(if_en),
        .inst_out(inst_out), .pc2_out(pc2_out), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program order from an address: sequential words until a halt opcode.
    task automatic load_stream(input logic [7:0] a);
        logic [7:0] p2;
        q.delete();
        for (int i = 0; i < 130; i++) begin
            p2 = a + 8'd2;
            q.push_back('{inst: mem[a], pc2: p2});
            if (mem[a][15:12] == 4'hF) break;
            a = p2;
        end
    endtask

    task automatic cycle(input logic st, input logic br, input logic [7:0] tg, input logic r);
        @(posedge clk);
        if (imem_ack || rst) busy = 1'b0;
        else if (busy) cnt++;
        #1;
        stall = st; br_taken = br; br_target = tg; rst = r;
        if (r) begin
            load_stream(RPC);
            halt_seen = 1'b0;
        end else if (br) begin
            load_stream(tg);
            halt_seen = 1'b0;
        end
        #1;
        imem_ack = 1'b0;
        imem_rdata = 16'h0000;
        if (!rst) begin
            if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1; cnt = 0; addr_l = imem_addr;
                    lat = $urandom_range(0, max_lat);
                end else chk("addr_stable", imem_addr, addr_l);
                if (cnt >= lat) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem[addr_l];
                end
            end else if (busy) chk("req_held", imem_req, 1);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) chk("req_in_reset", imem_req, 0);
            else begin
                if (stall || br_taken) chk("if_en_blocked", if_en, 0);
                if (if_en) begin
                    if (q.size() == 0) chk("unexpected_delivery", if_en, 0);
                    else begin
                        e = q.pop_front();
                        chk("inst_out", inst_out, e.inst);
                        chk("pc2_out", pc2_out, e.pc2);
                        if (e.inst[15:12] == 4'hF) halt_seen = 1'b1;
                    end
                end else if (halt_seen) begin
                    chk("halted_flag", halted, 1);
                    chk("halted_no_req", imem_req, 0);
                end
            end
        end
    end

    initial begin
        logic [7:0] tg;
        for (int i = 0; i < 256; i++)
            mem[i] = {($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14)), 12'($urandom)};
        mem[8'h10] = 16'h1234; mem[8'h12] = 16'h2345; mem[8'h14] = 16'h3456;
        mem[8'h16] = 16'h4567; mem[8'h18] = 16'h5678;
        mem[8'h08] = 16'hF000; mem[8'hFE] = 16'h1111;
        cycle(0, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 1);
        chk("rst_req", imem_req, 0);
        cycle(0, 0, 8'h00, 0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_req_after", imem_req, 1);
        chk("rst_if_en", if_en, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_pc2", pc2_out, 0);
        chk("rst_halted", halted, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 8'h00, 0);
            chk("stream_if_en", if_en, 1);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 8'h00, 0);
            chk("stall_if_en", if_en, 0);
            chk("stall_inst", inst_out, 16'h4567);
            chk("stall_pc2", pc2_out, 8'h18);
            chk("stall_req", imem_req, 0);
        end
        cycle(0, 0, 8'h00, 0);
        chk("release_if_en", if_en, 1);
        chk("release_addr", imem_addr, 8'h18);
        cycle(0, 1, 8'h08, 0);
        cycle(0, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 0);
        chk("halt_if_en", if_en, 1);
        chk("halt_pc2", pc2_out, 8'h0A);
        chk("halt_flag", halted, 1);
        chk("halt_req", imem_req, 0);
        cycle(0, 0, 8'h00, 0);
        cycle(0, 1, 8'h20, 0);
        cycle(0, 0, 8'h00, 0);
        chk("resume_halted", halted, 0);
        chk("resume_addr", imem_addr, 8'h20);
        chk("resume_req", imem_req, 1);
        cycle(0, 1, 8'hFE, 0);
        cycle(0, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 0);
        chk("wrap_if_en", if_en, 1);
        chk("wrap_pc2", pc2_out, 8'h00);
        chk("wrap_addr", imem_addr, 8'h00);
        max_lat = 3;
        cycle(0, 1, 8'h40, 0);
        cycle(0, 0, 8'h00, 0);
        for (int i = 0; i < 4000; i++) begin
            tg = ($urandom_range(0, 7) == 0) ? 8'hFE : 8'($urandom_range(0, 127) << 1);
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tg, $urandom_range(0, 299) == 0);
        end
        cycle(0, 0, 8'h00, 0);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
